// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states, lane constants and address helpers.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_DEPTH  = 256;
  localparam int APB_WAIT   = 0;
  localparam int APB_LANES  = APB_DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_state_e;

  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // True when the byte address is not on a word boundary.
  function automatic logic misaligned(input logic [63:0] addr, input int lbits);
    logic [63:0] mask;
    mask = (64'd1 << lbits) - 64'd1;
    return (addr & mask) != 64'd0;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Byte-enabled word memory with reset clear, one write port and a registered read port.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int DEPTH      = APB_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else if (we) begin
      for (int b = 0; b < LANES; b++)
        if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Read data is zero unless a read is being launched, so it doubles as PRDATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= re ? mem[ridx] : '0;
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: byte-enabled word memory with programmable wait states and error response.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = APB_ADDR_W,
  parameter int                    DATA_WIDTH  = APB_DATA_W,
  parameter int                    DEPTH       = APB_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = APB_WAIT
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [2:0]              PPROT,
  input  logic                    PNSE,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PWAKEUP,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int LB    = lane_bits(DATA_WIDTH);
  localparam int IDX_W = $clog2(DEPTH);

  apb_state_e            state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      idx_p0;
  logic                  err_p0;
  logic                  wr_p0;

  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  setup;
  logic                  enter_done;
  logic                  re;
  logic [IDX_W-1:0]      ridx;
  logic                  we;
  logic                  unused_in;

  assign unused_in = ^{PPROT, PWAKEUP};

  // Address decode for the setup edge; wrap-around below BASE_ADDR lands out of range.
  assign off     = PADDR - BASE_ADDR;
  assign dec_idx = off[LB +: IDX_W];
  assign dec_err = (|(off >> (LB + IDX_W))) || misaligned(64'(PADDR), LB) || PNSE;

  assign setup      = (state == IDLE) && PSEL && !PENABLE;
  assign enter_done = (setup && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && PSEL && PENABLE && (cnt == 4'd1));

  always_comb begin
    re   = 1'b0;
    ridx = idx_p0;
    if (state == IDLE) begin
      ridx = dec_idx;
      re   = enter_done && !dec_err && !PWRITE;
    end else begin
      re   = enter_done && !err_p0 && !wr_p0;
    end
  end

  assign we = (state == DONE) && wr_p0 && !err_p0 && PSEL && PENABLE;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_p0  <= '0;
      err_p0  <= 1'b0;
      wr_p0   <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      case (state)
        IDLE: begin
          if (setup) begin
            idx_p0 <= dec_idx;
            err_p0 <= dec_err;
            wr_p0  <= PWRITE;
            if (WAIT_STATES == 0) begin
              state   <= DONE;
              PREADY  <= 1'b1;
              PSLVERR <= dec_err;
            end else begin
              cnt   <= 4'(WAIT_STATES);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state   <= DONE;
              PREADY  <= 1'b1;
              PSLVERR <= err_p0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk   (PCLK),
    .rst_n (PRESET),
    .we    (we),
    .widx  (idx_p0),
    .wdata (PWDATA),
    .wstrb (PSTRB),
    .re    (re),
    .ridx  (ridx),
    .rdata (PRDATA)
  );

endmodule
